// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants, framer state encoding and the byte-wise CRC16 step
// used by both the transmit framer and the receiver's CRC check.
package modbus_pkg;

    localparam logic [7:0]  FC_READ_HOLD     = 8'h03;
    localparam logic [7:0]  FC_READ_INPUT    = 8'h04;
    localparam logic [7:0]  FC_WRITE_SINGLE  = 8'h06;
    localparam logic [7:0]  EXC_ILLEGAL_FUNC = 8'h01;
    localparam logic [7:0]  EXC_FLAG         = 8'h80;
    localparam logic [15:0] CRC_INIT         = 16'hFFFF;
    localparam logic [15:0] CRC_POLY         = 16'hA001;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_BCNT,
        ST_RDREQ,
        ST_DHI,
        ST_DLO,
        ST_ECHO,
        ST_ECODE,
        ST_CRCL,
        ST_CRCH
    } tx_state_e;

    typedef enum logic [1:0] {
        FT_RD,
        FT_WR,
        FT_EXC
    } frame_type_e;

    // Reflected CRC16: fold the byte into the low end, then shift out eight bits LSB-first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Modbus CRC16 accumulator: one byte per enabled cycle, synchronous re-init.
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            crc_q <= CRC_INIT;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc16_update(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/modbus_tx_framer.sv
// Modbus RTU slave reply framer: builds read/echo/exception frames, pulls register
// words from the handler's DPRAM and streams bytes plus CRC over valid/ready.
//
// state    | meaning
// IDLE     | waiting for tx_start; request fields latched on acceptance
// LOAD     | CRC cleared, slave address presented
// HDR      | slave address, then function byte
// BCNT     | read reply byte count
// RDREQ    | DPRAM read bubble, word captured at end of cycle
// DHI/DLO  | high / low byte of the current register word
// ECHO     | write-single echo: addr hi/lo, data hi/lo
// ECODE    | exception code byte
// CRCL/CRCH| CRC low / high byte; frame_done after CRCH is accepted
module modbus_tx_framer
    import modbus_pkg::*;
#(
    parameter logic [7:0] SADDR   = 8'h01,
    parameter logic [7:0] MAX_QTY = 8'd125
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        tx_start,
    input  logic [7:0]  func_code,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    input  logic [7:0]  tx_quantity,
    input  logic [7:0]  exception_code,
    output logic [7:0]  dpram_raddr,
    input  logic [15:0] dpram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_busy,
    output logic        frame_done
);

    tx_state_e   state_q;
    frame_type_e ftype_q;
    logic [7:0]  func_q;
    logic [7:0]  code_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [7:0]  words_left_q;
    logic [7:0]  raddr_q;
    logic [7:0]  lo_byte_q;
    logic [1:0]  sel_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        done_q;

    logic        xfer;
    logic        payload_st;
    logic        crc_init;
    logic        crc_en;
    logic [15:0] crc_q;
    logic [7:0]  func_byte;
    logic [7:0]  byte_count;

    assign xfer       = tx_valid_q && tx_ready;
    assign payload_st = (state_q == ST_HDR)  || (state_q == ST_BCNT) ||
                        (state_q == ST_DHI)  || (state_q == ST_DLO)  ||
                        (state_q == ST_ECHO) || (state_q == ST_ECODE);
    assign crc_init   = (state_q == ST_LOAD);
    assign crc_en     = xfer && payload_st;
    assign func_byte  = (ftype_q == FT_EXC) ? (func_q | EXC_FLAG) : func_q;
    // qty is clamped to 125, so the doubled count never reaches bit 8.
    assign byte_count = {words_left_q[6:0], 1'b0};

    modbus_crc16 u_crc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .init_i   (crc_init),
        .en_i     (crc_en),
        .data_i   (tx_data),
        .crc_o    (crc_q)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            ftype_q      <= FT_EXC;
            func_q       <= 8'h00;
            code_q       <= 8'h00;
            addr_q       <= 16'h0000;
            data_q       <= 16'h0000;
            words_left_q <= 8'h00;
            raddr_q      <= 8'h00;
            lo_byte_q    <= 8'h00;
            sel_q        <= 2'd0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tx_start && !busy_q) begin
                        busy_q       <= 1'b1;
                        func_q       <= func_code;
                        addr_q       <= addr;
                        data_q       <= data;
                        words_left_q <= (tx_quantity > MAX_QTY) ? MAX_QTY : tx_quantity;
                        if (exception_code != 8'h00) begin
                            ftype_q <= FT_EXC;
                            code_q  <= exception_code;
                        end else if ((func_code == FC_READ_HOLD) || (func_code == FC_READ_INPUT)) begin
                            ftype_q <= FT_RD;
                        end else if (func_code == FC_WRITE_SINGLE) begin
                            ftype_q <= FT_WR;
                        end else begin
                            ftype_q <= FT_EXC;
                            code_q  <= EXC_ILLEGAL_FUNC;
                        end
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_q  <= SADDR;
                    tx_valid_q <= 1'b1;
                    sel_q      <= 2'd0;
                    raddr_q    <= 8'h00;
                    state_q    <= ST_HDR;
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (!sel_q[0]) begin
                            tx_data_q <= func_byte;
                            sel_q     <= 2'd1;
                        end else begin
                            case (ftype_q)
                                FT_RD: begin
                                    tx_data_q <= byte_count;
                                    state_q   <= ST_BCNT;
                                end
                                FT_WR: begin
                                    tx_data_q <= addr_q[15:8];
                                    sel_q     <= 2'd0;
                                    state_q   <= ST_ECHO;
                                end
                                default: begin
                                    tx_data_q <= code_q;
                                    state_q   <= ST_ECODE;
                                end
                            endcase
                        end
                    end
                end
                ST_BCNT: begin
                    if (xfer) begin
                        if (words_left_q == 8'd0) begin
                            state_q <= ST_CRCL;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_RDREQ;
                        end
                    end
                end
                ST_RDREQ: begin
                    lo_byte_q  <= dpram_rdata[7:0];
                    tx_data_q  <= dpram_rdata[15:8];
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_DHI;
                end
                ST_DHI: begin
                    if (xfer) begin
                        tx_data_q <= lo_byte_q;
                        // Advance the address a byte early so the registered DPRAM
                        // output is ready by the next RDREQ; stop on the last word.
                        if (words_left_q != 8'd1) begin
                            raddr_q <= raddr_q + 8'd1;
                        end
                        state_q <= ST_DLO;
                    end
                end
                ST_DLO: begin
                    if (xfer) begin
                        words_left_q <= words_left_q - 8'd1;
                        if (words_left_q == 8'd1) begin
                            state_q <= ST_CRCL;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_RDREQ;
                        end
                    end
                end
                ST_ECHO: begin
                    if (xfer) begin
                        sel_q <= sel_q + 2'd1;
                        case (sel_q)
                            2'd0:    tx_data_q <= addr_q[7:0];
                            2'd1:    tx_data_q <= data_q[15:8];
                            2'd2:    tx_data_q <= data_q[7:0];
                            default: state_q   <= ST_CRCL;
                        endcase
                    end
                end
                ST_ECODE: begin
                    if (xfer) begin
                        state_q <= ST_CRCL;
                    end
                end
                ST_CRCL: begin
                    if (xfer) begin
                        tx_data_q <= crc_q[15:8];
                        state_q   <= ST_CRCH;
                    end
                end
                ST_CRCH: begin
                    if (xfer) begin
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The CRC only settles on the edge that accepts the last payload byte,
    // so the low CRC byte is taken straight from the accumulator while in CRCL.
    assign tx_data     = (state_q == ST_CRCL) ? crc_q[7:0] : tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign dpram_raddr = raddr_q;
    assign tx_busy     = busy_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_modbus_tx_framer.sv
// Directed self-checking bench for modbus_tx_framer: captures accepted bytes and
// compares complete frames, busy length and frame_done pulses against hand values.
module tb_modbus_tx_framer;

    typedef logic [7:0] bq_t[$];

    logic        clk_in         = 1'b0;
    logic        rst_n_in       = 1'b0;
    logic        tx_start       = 1'b0;
    logic [7:0]  func_code      = 8'h00;
    logic [15:0] addr           = 16'h0000;
    logic [15:0] data           = 16'h0000;
    logic [7:0]  tx_quantity    = 8'h00;
    logic [7:0]  exception_code = 8'h00;
    logic [7:0]  dpram_raddr;
    logic [15:0] dpram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready       = 1'b1;
    logic        tx_busy;
    logic        frame_done;

    logic [15:0] mem [0:255];
    int          n_cmp     = 0;
    int          n_bad     = 0;
    bq_t         got;
    int          busy_cnt  = 0;
    int          done_cnt  = 0;
    int          max_raddr = 0;
    int          rdy_mode  = 0;
    int          cyc       = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held       = 8'h00;

    modbus_tx_framer #(.SADDR(8'h01), .MAX_QTY(8'd125)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .tx_start       (tx_start),
        .func_code      (func_code),
        .addr           (addr),
        .data           (data),
        .tx_quantity    (tx_quantity),
        .exception_code (exception_code),
        .dpram_raddr    (dpram_raddr),
        .dpram_rdata    (dpram_rdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_busy        (tx_busy),
        .frame_done     (frame_done)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read DPRAM: data appears one cycle after the address.
    always @(posedge clk_in) dpram_rdata <= mem[dpram_raddr];

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            tx_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (tx_busy) busy_cnt++;
        if (frame_done) done_cnt++;
        if (int'(dpram_raddr) > max_raddr) max_raddr = int'(dpram_raddr);
        if (stall_prev && rst_n_in) begin
            chk("stall_valid", {31'd0, tx_valid}, 32'd1);
            chk("stall_data", {24'd0, tx_data}, {24'd0, held});
        end
        stall_prev = tx_valid && !tx_ready && rst_n_in;
        held       = tx_data;
    end

    function automatic bq_t with_crc(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        bq_t r = b;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                logic fb;
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
        return r;
    endfunction

    task automatic send(input logic [7:0] fc, input logic [15:0] a, input logic [15:0] d,
                        input logic [7:0] q, input logic [7:0] exc);
        @(posedge clk_in);
        #1;
        got.delete();
        busy_cnt       = 0;
        done_cnt       = 0;
        max_raddr      = 0;
        func_code      = fc;
        addr           = a;
        data           = d;
        tx_quantity    = q;
        exception_code = exc;
        tx_start       = 1'b1;
        @(posedge clk_in);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, {31'd0, (n < limit)}, 32'd1);
        repeat (3) @(negedge clk_in);
    endtask

    task automatic check_frame(input string tag, input bq_t exp);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data"},  {24'd0, tx_data},     32'd0);
        chk({tag, "_valid"}, {31'd0, tx_valid},    32'd0);
        chk({tag, "_raddr"}, {24'd0, dpram_raddr}, 32'd0);
        chk({tag, "_busy"},  {31'd0, tx_busy},     32'd0);
        chk({tag, "_done"},  {31'd0, frame_done},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t exp;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        repeat (3) @(negedge clk_in);
        check_reset("rst");
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // read holding, one word
        mem[0] = 16'h0001;
        send(8'h03, 16'h0000, 16'h0000, 8'd1, 8'h00);
        wait_done("rd1_done", 50);
        exp = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84};
        check_frame("rd1", exp);
        chk("rd1_busy", busy_cnt, 10);
        chk("rd1_pulses", done_cnt, 1);

        // write single echo
        send(8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00);
        wait_done("wr_done", 50);
        exp = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        check_frame("wr", exp);
        chk("wr_busy", busy_cnt, 10);

        // exception reply, no DPRAM activity
        send(8'h03, 16'h0000, 16'h0000, 8'd5, 8'h02);
        wait_done("exc_done", 50);
        exp = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        check_frame("exc", exp);
        chk("exc_busy", busy_cnt, 7);
        chk("exc_raddr", max_raddr, 0);

        // read input, four words, receiver stalls two of every three cycles
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        rdy_mode = 1;
        send(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
        wait_done("rd4_done", 300);
        rdy_mode = 0;
        exp = with_crc('{8'h01, 8'h04, 8'h08, 8'h11, 8'h11, 8'h22, 8'h22,
                         8'h33, 8'h33, 8'h44, 8'h44});
        check_frame("rd4", exp);
        chk("rd4_raddr_max", max_raddr, 3);
        chk("rd4_pulses", done_cnt, 1);

        // zero-quantity read
        send(8'h03, 16'h0000, 16'h0000, 8'd0, 8'h00);
        wait_done("rd0_done", 50);
        exp = with_crc('{8'h01, 8'h03, 8'h00});
        check_frame("rd0", exp);
        chk("rd0_busy", busy_cnt, 7);

        // oversize read clamped to 125 words
        for (int i = 0; i < 125; i++) begin
            logic [7:0] v;
            v = i[7:0];
            mem[i] = {v, v ^ 8'h5A};
        end
        send(8'h03, 16'h0000, 16'h0000, 8'd200, 8'h00);
        wait_done("rd200_done", 1000);
        exp = '{8'h01, 8'h03, 8'hFA};
        for (int i = 0; i < 125; i++) begin
            logic [7:0] v;
            v = i[7:0];
            exp.push_back(v);
            exp.push_back(v ^ 8'h5A);
        end
        exp = with_crc(exp);
        check_frame("rd200", exp);
        chk("rd200_busy", busy_cnt, 382);
        chk("rd200_raddr_max", max_raddr, 124);

        // unsupported function -> illegal function exception
        send(8'h10, 16'h0000, 16'h0000, 8'd0, 8'h00);
        wait_done("ill_done", 50);
        exp = with_crc('{8'h01, 8'h90, 8'h01});
        check_frame("ill", exp);

        // second start while busy must be ignored
        send(8'h06, 16'h1234, 16'hABCD, 8'd0, 8'h00);
        repeat (3) @(posedge clk_in);
        #1;
        func_code = 8'h03; tx_quantity = 8'd1; tx_start = 1'b1;
        @(posedge clk_in);
        #1 tx_start = 1'b0;
        wait_done("ign_done", 50);
        repeat (15) @(negedge clk_in);
        exp = with_crc('{8'h01, 8'h06, 8'h12, 8'h34, 8'hAB, 8'hCD});
        check_frame("ign", exp);
        chk("ign_pulses", done_cnt, 1);

        // reset in the middle of the data phase
        send(8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
        repeat (6) @(negedge clk_in);
        #1 rst_n_in = 1'b0;
        @(negedge clk_in);
        check_reset("midrst");
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("midrst_pulses", done_cnt, 0);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd0);

        // clean frame after the abort
        send(8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00);
        wait_done("post_done", 50);
        exp = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        check_frame("post", exp);
        chk("post_busy", busy_cnt, 10);
        chk("post_pulses", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modbus_tx_framer.md
Name: modbus_tx_framer

Overview:
- Response side of the Modbus RTU slave; companion to the function handler.
- On the handler's one-cycle done pulse, builds the reply frame: normal 03/04 read reply, 06 echo, or exception.
- Fetches register words from the DPRAM read port that the handler filled, appends CRC16, and streams bytes to the UART transmitter over a valid/ready byte handshake.

Parameters:
SADDR, 8'h01, slave address placed in byte 0 of every frame
MAX_QTY, 8'd125, maximum register count per read reply; larger tx_quantity is clamped to this

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
tx_start  input  1  one-cycle pulse from the handler's handler_done
func_code  input  8  latched request function code
addr  input  16  latched request register address (06 echo)
data  input  16  latched request data/quantity (06 echo)
tx_quantity  input  8  number of register words in the DPRAM for a 03/04 reply
exception_code  input  8  0 = normal reply; nonzero = Modbus exception code
dpram_raddr  output  8  DPRAM read address
dpram_rdata  input  16  DPRAM read data, valid 1 cycle after dpram_raddr
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART transmitter can accept a byte
tx_busy  output  1  high from the accepted start until frame_done
frame_done  output  1  one-cycle pulse after the last CRC byte is accepted

Behaviour:
- Reset values: tx_data=0, tx_valid=0, dpram_raddr=0, tx_busy=0, frame_done=0. The FSM goes to IDLE and the CRC register loads 16'hFFFF.
- Reset asserted mid-frame aborts immediately. No partial resumption.
- tx_start in IDLE latches all inputs. Frame type is chosen once at latch time:
  - EXC if exception_code!=0.
  - Else RD for func 03/04.
  - Else WR for func 06.
  - Else EXC with code 8'h01.
- tx_start while tx_busy is ignored.
- Frame contents:
  - RD: SADDR, func, bytecount=2*qty, then hi/lo byte per word, CRC lo, CRC hi.
  - WR: SADDR, 06, addr hi, addr lo, data hi, data lo, CRC lo, CRC hi.
  - EXC: SADDR, func|8'h80, code, CRC lo, CRC hi.
- qty is min(tx_quantity, MAX_QTY). bytecount is computed in 9 bits and truncated to 8 (max 250).
- qty=0 in RD sends bytecount 8'h00 with no data bytes, then the CRC.
- Byte handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_data is held stable while tx_valid && !tx_ready.
  - tx_valid may stay high back-to-back between bytes.
- CRC16 Modbus: init FFFF, reflected poly A001, LSB-first. It updates on each transferred payload byte (not on CRC bytes), one byte per cycle.
- FSM states:
  - IDLE: tx_start -> LOAD. tx_busy=1 from the next cycle.
  - LOAD: latch inputs, clear CRC -> HDR.
  - HDR: send SADDR, then the function byte. Then RD -> BCNT, WR -> ECHO, EXC -> ECODE.
  - BCNT: send bytecount. qty==0 -> CRCL, else -> RDREQ with dpram_raddr=0.
  - RDREQ: wait one cycle for read latency, then capture dpram_rdata into the word buffer -> DHI.
  - DHI: send buffer[15:8] -> DLO.
  - DLO: send buffer[7:0]. Then dpram_raddr++. If index == qty-1 -> CRCL, else -> RDREQ.
  - ECHO: four bytes from the latched addr/data -> CRCL.
  - ECODE: send code -> CRCL.
  - CRCL: send crc[7:0] -> CRCH.
  - CRCH: send crc[15:8]. On acceptance, pulse frame_done, drop tx_busy -> IDLE.
- Total cycles with tx_ready tied high: RD = 7 + 3*qty (DPRAM bubble per word); WR = 10; EXC = 7 (LOAD..frame_done).
- The 3.5-character inter-frame silence is owned by the UART transmitter, not this block.

Decomposition:
- Shared package modbus_pkg:
  - function codes FC_READ_HOLD=8'h03, FC_READ_INPUT=8'h04, FC_WRITE_SINGLE=8'h06
  - EXC_ILLEGAL_FUNC=8'h01, EXC_FLAG=8'h80
  - CRC_INIT=16'hFFFF, CRC_POLY=16'hA001
  - FSM state encoding
- Sub-module modbus_crc16: init/enable/data[7:0] inputs, crc[15:0] registered output, 8-bit combinational unroll per cycle. It is shared with the receiver's CRC check.

Test Plan:
- SADDR=01, func 03, qty=1, DPRAM[0]=0x0001, tx_ready=1 -> bytes 01 03 02 00 01 79 84; frame_done once; tx_busy high 10 cycles.
- func 06, addr=0x0001, data=0x0003 -> bytes 01 06 00 01 00 03 98 0B.
- exception_code=02, func 03 -> bytes 01 83 02 C0 F1; no DPRAM reads (dpram_raddr stays 0).
- func 04, qty=4, DPRAM[0..3]=1111,2222,3333,4444, tx_ready toggling 1-of-3 cycles -> bytecount 08, data in order, tx_data stable while stalled, dpram_raddr 0..3, CRC matches reference model.
- func 03 with qty=0, then qty=200 -> 01 03 00 + CRC; second frame bytecount FA with 125 words.
- Stimulus sequence:
  - tx_start during busy -> ignored.
  - rst_n_in low mid-data, then released -> outputs at reset values.
  - Next tx_start -> a clean, correct frame.
